// File: rtl/lval_align_pkg.sv
// Shared types and widths for the LVDS link-training sequencer.
// Imported by the controller, its skew monitor and the bus interface.
package lval_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLIP,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_e;

    localparam int WORD_W   = 12;
    localparam int SLIP_MAX = 11;
    localparam int CNT_W    = 8;
    localparam int TO_W     = 16;
    localparam int SLIP_W   = 4;
    localparam int ELANE_W  = 4;

    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lval_align_ctrl_if.sv
// Receive-path bus between the deserialisers/aligners and the training sequencer.
// master drives words and requests; slave is the sequencer.
interface lval_align_ctrl_if #(
    parameter int LANES = 8
);
    import lval_align_pkg::*;

    logic                      train_req;
    logic [LANES-1:0]          data_valid;
    logic [LANES*WORD_W-1:0]   data_in;
    logic [LANES-1:0]          sync_valid;
    logic [LANES-1:0]          bitslip;
    logic [LANES-1:0]          lane_lock;
    logic                      align_done;
    logic                      align_err;
    logic [ELANE_W-1:0]        err_lane;
    logic                      busy;

    modport master (
        output train_req, data_valid, data_in, sync_valid,
        input  bitslip, lane_lock, align_done, align_err, err_lane, busy
    );

    modport slave (
        input  train_req, data_valid, data_in, sync_valid,
        output bitslip, lane_lock, align_done, align_err, err_lane, busy
    );

endinterface

// File: rtl/lval_skew_mon.sv
// Counts consecutive cycles of sync-valid skew across lanes while enabled and
// reports the lowest lane whose sync_valid disagrees with lane 0.
module lval_skew_mon
    import lval_align_pkg::*;
#(
    parameter int LANES        = 8,
    parameter int MISALIGN_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [LANES-1:0]   sync_valid,
    output logic               timeout,
    output logic [ELANE_W-1:0] diff_lane
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             skew;

    // Skew detect, timeout strobe and next count; any clean cycle restarts the run.
    always_comb begin
        skew    = (sync_valid != '0) && (sync_valid != '1);
        timeout = en && skew && (cnt_q == CNT_W'(MISALIGN_MAX - 1));
        cnt_d   = '0;
        if (en && skew && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Lowest lane that differs from lane 0; scanning downward leaves the lowest hit.
    always_comb begin
        diff_lane = '0;
        for (int i = LANES - 1; i >= 1; i--) begin
            if (sync_valid[i] != sync_valid[0]) begin
                diff_lane = ELANE_W'(i);
            end
        end
    end

    // Skew run-length register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lval_align_ctrl.sv
// LVDS link-training sequencer: slips each lane in turn until it shows the
// training word, locks it, then watches sync-valid skew once all lanes are up.
module lval_align_ctrl
    import lval_align_pkg::*;
#(
    parameter int                lvds_pairs   = 8,
    parameter logic [WORD_W-1:0] TRAIN_WORD   = 12'hF0C,
    parameter int                MATCH_CNT    = 16,
    parameter int                SETTLE_CYC   = 8,
    parameter int                CHECK_TO     = 64,
    parameter int                MISALIGN_MAX = 4,
    parameter bit                AUTO_RETRAIN = 1'b1
) (
    input  logic             clk_rxg,
    input  logic             rst_rx,
    lval_align_ctrl_if.slave bus
);

    localparam int                  LW        = lane_w(lvds_pairs);
    localparam logic [LW-1:0]       LAST_LANE = LW'(lvds_pairs - 1);
    localparam logic [lvds_pairs-1:0] LANE_ONE = lvds_pairs'(1);

    state_e              state_q, state_d;
    logic [LW-1:0]       lane_idx_q, lane_idx_d;
    logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;
    logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                wvalid_q, wvalid_d;

    logic [lvds_pairs-1:0] bitslip_q, bitslip_d;
    logic [lvds_pairs-1:0] lane_lock_q, lane_lock_d;
    logic                  align_done_q, align_done_d;
    logic                  align_err_q, align_err_d;
    logic [ELANE_W-1:0]    err_lane_q, err_lane_d;
    logic                  busy_q, busy_d;

    logic                start_ev;
    logic                lock_ev;
    logic                fail_ev;
    logic                miss;
    logic [ELANE_W-1:0]  fail_lane;
    logic                skew_to;
    logic [ELANE_W-1:0]  skew_lane;

    lval_skew_mon #(
        .LANES        (lvds_pairs),
        .MISALIGN_MAX (MISALIGN_MAX)
    ) u_skew_mon (
        .clk        (clk_rxg),
        .rst        (rst_rx),
        .en         (state_q == ST_DONE),
        .sync_valid (bus.sync_valid),
        .timeout    (skew_to),
        .diff_lane  (skew_lane)
    );

    // Next state, counters and the training events that feed the outputs.
    always_comb begin
        state_d      = state_q;
        lane_idx_d   = lane_idx_q;
        slip_cnt_d   = slip_cnt_q;
        match_cnt_d  = match_cnt_q;
        settle_cnt_d = settle_cnt_q;
        to_cnt_d     = to_cnt_q;
        start_ev     = 1'b0;
        lock_ev      = 1'b0;
        fail_ev      = 1'b0;
        miss         = 1'b0;
        fail_lane    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.train_req) begin
                    start_ev = 1'b1;
                end
            end
            ST_SLIP: begin
                slip_cnt_d   = slip_cnt_q + 1'b1;
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    settle_cnt_d = '0;
                    match_cnt_d  = '0;
                    to_cnt_d     = '0;
                    state_d      = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (wvalid_q) begin
                    to_cnt_d = '0;
                    if (word_q == TRAIN_WORD) begin
                        if (match_cnt_q == CNT_W'(MATCH_CNT - 1)) begin
                            lock_ev     = 1'b1;
                            match_cnt_d = '0;
                            if (lane_idx_q == LAST_LANE) begin
                                state_d = ST_DONE;
                            end else begin
                                lane_idx_d = lane_idx_q + 1'b1;
                                slip_cnt_d = '0;
                            end
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else begin
                        miss = 1'b1;
                    end
                end else if (to_cnt_q == TO_W'(CHECK_TO - 1)) begin
                    miss = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                if (miss) begin
                    match_cnt_d = '0;
                    to_cnt_d    = '0;
                    if (slip_cnt_q == SLIP_W'(SLIP_MAX)) begin
                        fail_ev   = 1'b1;
                        fail_lane = ELANE_W'(lane_idx_q);
                        state_d   = ST_FAIL;
                    end else begin
                        state_d = ST_SLIP;
                    end
                end
            end
            ST_DONE: begin
                if (bus.train_req || (skew_to && AUTO_RETRAIN)) begin
                    start_ev = 1'b1;
                end else if (skew_to) begin
                    fail_ev   = 1'b1;
                    fail_lane = skew_lane;
                    state_d   = ST_FAIL;
                end
            end
            ST_FAIL: begin
                if (bus.train_req) begin
                    start_ev = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start_ev) begin
            state_d      = ST_CHECK;
            lane_idx_d   = '0;
            slip_cnt_d   = '0;
            match_cnt_d  = '0;
            settle_cnt_d = '0;
            to_cnt_d     = '0;
        end
    end

    // Registered outputs derived from the upcoming state and training events.
    always_comb begin
        bitslip_d    = (state_d == ST_SLIP) ? (LANE_ONE << lane_idx_d) : '0;
        busy_d       = (state_d == ST_SLIP) || (state_d == ST_SETTLE) ||
                       (state_d == ST_CHECK);
        align_done_d = (state_d == ST_DONE);
        lane_lock_d  = lane_lock_q;
        align_err_d  = align_err_q;
        err_lane_d   = err_lane_q;
        if (start_ev) begin
            lane_lock_d = '0;
            align_err_d = 1'b0;
            err_lane_d  = '0;
        end
        if (lock_ev) begin
            lane_lock_d = lane_lock_q | (LANE_ONE << lane_idx_q);
        end
        if (fail_ev) begin
            align_err_d = 1'b1;
            err_lane_d  = fail_lane;
        end
    end

    // Lane word mux follows the next lane index so a freshly selected lane is
    // compared from its first CHECK cycle.
    always_comb begin
        word_d   = '0;
        wvalid_d = 1'b0;
        for (int i = 0; i < lvds_pairs; i++) begin
            if (lane_idx_d == LW'(i)) begin
                word_d   = bus.data_in[i*WORD_W +: WORD_W];
                wvalid_d = bus.data_valid[i];
            end
        end
    end

    // State, counter, mux and output registers.
    always_ff @(posedge clk_rxg or posedge rst_rx) begin
        if (rst_rx) begin
            state_q      <= ST_IDLE;
            lane_idx_q   <= '0;
            slip_cnt_q   <= '0;
            match_cnt_q  <= '0;
            settle_cnt_q <= '0;
            to_cnt_q     <= '0;
            word_q       <= '0;
            wvalid_q     <= 1'b0;
            bitslip_q    <= '0;
            lane_lock_q  <= '0;
            align_done_q <= 1'b0;
            align_err_q  <= 1'b0;
            err_lane_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_idx_q   <= lane_idx_d;
            slip_cnt_q   <= slip_cnt_d;
            match_cnt_q  <= match_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            to_cnt_q     <= to_cnt_d;
            word_q       <= word_d;
            wvalid_q     <= wvalid_d;
            bitslip_q    <= bitslip_d;
            lane_lock_q  <= lane_lock_d;
            align_done_q <= align_done_d;
            align_err_q  <= align_err_d;
            err_lane_q   <= err_lane_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.bitslip    = bitslip_q;
    assign bus.lane_lock  = lane_lock_q;
    assign bus.align_done = align_done_q;
    assign bus.align_err  = align_err_q;
    assign bus.err_lane   = err_lane_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_lval_align_ctrl.sv
// Bench for lval_align_ctrl: lanes are modelled as rotating serdes words whose
// phase advances on each bitslip; two DUTs differ only in AUTO_RETRAIN.
module tb_lval_align_ctrl;

    localparam int          N      = 8;
    localparam int          MATCH  = 16;
    localparam int          SETTLE = 8;
    localparam int          CTO    = 64;
    localparam int          MIS    = 4;
    localparam logic [11:0] TW     = 12'hF0C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            train_req = 1'b0;
    logic [N-1:0]    sv = '1;
    logic [N-1:0]    dv;
    logic [N*12-1:0] din;

    lval_align_ctrl_if #(.LANES(N)) ifa ();
    lval_align_ctrl_if #(.LANES(N)) ifb ();

    assign ifa.train_req  = train_req;
    assign ifa.data_valid = dv;
    assign ifa.data_in    = din;
    assign ifa.sync_valid = sv;
    assign ifb.train_req  = train_req;
    assign ifb.data_valid = dv;
    assign ifb.data_in    = din;
    assign ifb.sync_valid = sv;

    lval_align_ctrl #(
        .lvds_pairs(N), .TRAIN_WORD(TW), .MATCH_CNT(MATCH), .SETTLE_CYC(SETTLE),
        .CHECK_TO(CTO), .MISALIGN_MAX(MIS), .AUTO_RETRAIN(1'b1)
    ) dut_a (.clk_rxg(clk), .rst_rx(rst), .bus(ifa));

    lval_align_ctrl #(
        .lvds_pairs(N), .TRAIN_WORD(TW), .MATCH_CNT(MATCH), .SETTLE_CYC(SETTLE),
        .CHECK_TO(CTO), .MISALIGN_MAX(MIS), .AUTO_RETRAIN(1'b0)
    ) dut_b (.clk_rxg(clk), .rst_rx(rst), .bus(ifb));

    int checks = 0;
    int fails  = 0;

    logic [N-1:0][3:0] ph0 = '0;
    logic [N-1:0]      never_m = '0;
    logic [N-1:0]      noval_m = '0;
    bit                gaps = 1'b0;
    bit                clr = 1'b0;
    int                slips [N];
    int                viol = 0;
    int                quiet = 1000;
    int                gp;

    function automatic logic [11:0] rot(input logic [11:0] w, input int k);
        logic [23:0] t;
        t = {w, w} << k;
        return t[23:12];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Lane model: count slips, police pulse shape, drive rotated words.
    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < N; i++) slips[i] = 0;
            quiet = 1000;
            viol  = 0;
        end else if (!rst) begin
            if (ifa.bitslip != '0) begin
                if ($countones(ifa.bitslip) != 1) viol++;
                if (quiet < SETTLE) viol++;
                if ((ifa.bitslip & ifa.lane_lock) != '0) viol++;
                quiet = 0;
                for (int i = 0; i < N; i++) if (ifa.bitslip[i]) slips[i]++;
            end else if (quiet < 1000) begin
                quiet++;
            end
        end
        for (int i = 0; i < N; i++) begin
            gp    = (int'(ph0[i]) + slips[i]) % 12;
            dv[i] = !noval_m[i] && (!gaps || ($urandom_range(3) != 0));
            if (!dv[i])          din[i*12 +: 12] = 12'($urandom);
            else if (never_m[i]) din[i*12 +: 12] = 12'h000;
            else                 din[i*12 +: 12] = rot(TW, gp);
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        train_req = 1'b0;
        sv        = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [N-1:0][3:0] p, input logic [N-1:0] nv,
                           input logic [N-1:0] no, input bit g);
        ph0     = p;
        never_m = nv;
        noval_m = no;
        gaps    = g;
        clr     = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic pulse_train();
        train_req = 1'b1;
        @(negedge clk);
        train_req = 1'b0;
    endtask

    task automatic wait_end(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (ifa.align_done || ifa.align_err) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [N-1:0][3:0] slip_vec();
        logic [N-1:0][3:0] r;
        for (int i = 0; i < N; i++) r[i] = 4'(slips[i]);
        return r;
    endfunction

    typedef struct {
        logic [N-1:0][3:0] ph;
        logic [N-1:0]      nev;
        logic [N-1:0]      nov;
        logic [N-1:0]      lock;
        bit                done;
        bit                err;
        int                elane;
        logic [N-1:0][3:0] sl;
    } vec_t;

    task automatic check_run(input string tag, input vec_t e);
        bit ok;
        wait_end(20000, ok);
        chk({tag, "_finish"}, ok, 1);
        @(negedge clk);
        chk({tag, "_lock"}, ifa.lane_lock, e.lock);
        chk({tag, "_done"}, ifa.align_done, e.done);
        chk({tag, "_err"}, ifa.align_err, e.err);
        chk({tag, "_elane"}, ifa.err_lane, e.elane);
        chk({tag, "_slips"}, slip_vec(), e.sl);
        chk({tag, "_lock_b"}, ifb.lane_lock, e.lock);
        chk({tag, "_viol"}, viol, 0);
    endtask

    vec_t tbl [5];
    vec_t ev;
    bit   ok;
    int   first_bad;

    initial begin
        tbl[0] = '{ph:32'h0, nev:8'h00, nov:8'h00, lock:8'hFF, done:1'b1,
                   err:1'b0, elane:0, sl:32'h0};
        tbl[1] = '{ph:32'h0000_7000, nev:8'h00, nov:8'h00, lock:8'hFF, done:1'b1,
                   err:1'b0, elane:0, sl:32'h0000_5000};
        tbl[2] = '{ph:32'h0, nev:8'h40, nov:8'h00, lock:8'h3F, done:1'b0,
                   err:1'b1, elane:6, sl:32'h0B00_0000};
        tbl[3] = '{ph:32'h0, nev:8'h00, nov:8'h04, lock:8'h03, done:1'b0,
                   err:1'b1, elane:2, sl:32'h0000_0B00};
        tbl[4] = '{ph:32'hB000_0001, nev:8'h00, nov:8'h00, lock:8'hFF, done:1'b1,
                   err:1'b0, elane:0, sl:32'h1000_000B};

        @(negedge clk);
        chk("reset_a", {ifa.bitslip, ifa.lane_lock, ifa.align_done, ifa.align_err,
                        ifa.err_lane, ifa.busy}, 0);
        chk("reset_b", {ifb.bitslip, ifb.lane_lock, ifb.align_done, ifb.align_err,
                        ifb.err_lane, ifb.busy}, 0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            set_cfg(tbl[v].ph, tbl[v].nev, tbl[v].nov, 1'b0);
            pulse_train();
            chk("start_busy", ifa.busy, 1);
            check_run($sformatf("vec%0d", v), tbl[v]);
        end

        // mid-training request ignored, then skew handling on both variants
        do_reset();
        set_cfg('0, '0, '0, 1'b1);
        pulse_train();
        for (int c = 0; c < 2000 && !ifa.lane_lock[2]; c++) @(negedge clk);
        pulse_train();
        chk("midreq_lock", ifa.lane_lock[2:0], 3'b111);
        chk("midreq_busy", ifa.busy, 1);
        wait_end(20000, ok);
        chk("skew_pre_done", {ifa.align_done, ifb.align_done}, 2'b11);
        sv = 8'hFE;
        repeat (3) @(negedge clk);
        sv = '1;
        @(negedge clk);
        chk("skew_break", {ifa.align_done, ifb.align_done}, 2'b11);
        sv = 8'hFE;
        repeat (3) @(negedge clk);
        chk("skew_3cyc", {ifa.align_done, ifb.align_done, ifb.align_err}, 3'b110);
        @(negedge clk);
        sv = '1;
        chk("skew_a_done", ifa.align_done, 0);
        chk("skew_a_lock", ifa.lane_lock, 0);
        chk("skew_a_busy", ifa.busy, 1);
        chk("skew_b_err", {ifb.align_done, ifb.align_err, ifb.err_lane}, {2'b01, 4'd1});
        wait_end(20000, ok);
        @(negedge clk);
        chk("retrain_a", {ifa.align_done, ifa.lane_lock}, {1'b1, 8'hFF});
        pulse_train();
        chk("req_done_a", {ifa.align_done, ifa.busy}, 2'b01);
        chk("req_fail_b", {ifb.align_err, ifb.busy}, 2'b01);
        wait_end(20000, ok);
        @(negedge clk);
        chk("rerun_b", {ifb.align_done, ifb.lane_lock}, {1'b1, 8'hFF});

        // asynchronous reset while lane 4 settles, then restart from lane 0
        do_reset();
        set_cfg(32'h0003_0000, '0, '0, 1'b0);
        pulse_train();
        for (int c = 0; c < 3000 && !ifa.bitslip[4]; c++) @(negedge clk);
        chk("l4_slip_seen", ifa.bitslip, 8'h10);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {ifa.bitslip, ifa.lane_lock, ifa.align_done, ifa.align_err,
                          ifa.err_lane, ifa.busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_quiet", {ifa.bitslip, ifa.busy}, 0);
        end
        set_cfg(32'h0000_0002, '0, '0, 1'b0);
        pulse_train();
        for (int c = 0; c < 200 && ifa.bitslip == '0; c++) @(negedge clk);
        chk("restart_lane0", ifa.bitslip, 8'h01);
        ev = '{ph:'0, nev:'0, nov:'0, lock:8'hFF, done:1'b1, err:1'b0, elane:0,
               sl:32'h0000_000A};
        check_run("restart", ev);

        // random phases and dead lanes against the lane-by-lane model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                ev.ph[i]  = 4'($urandom_range(11));
                ev.nev[i] = ($urandom_range(9) == 0);
            end
            ev.nov    = '0;
            first_bad = N;
            for (int i = N - 1; i >= 0; i--) if (ev.nev[i]) first_bad = i;
            for (int i = 0; i < N; i++) begin
                ev.lock[i] = (i < first_bad);
                if (i < first_bad)       ev.sl[i] = 4'((12 - int'(ev.ph[i])) % 12);
                else if (i == first_bad) ev.sl[i] = 4'd11;
                else                     ev.sl[i] = 4'd0;
            end
            ev.done  = (first_bad == N);
            ev.err   = (first_bad != N);
            ev.elane = (first_bad == N) ? 0 : first_bad;
            do_reset();
            set_cfg(ev.ph, ev.nev, ev.nov, 1'b1);
            pulse_train();
            check_run($sformatf("rand%0d", r), ev);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
